// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched word, reads operands (with WB bypass),
// detects load-use hazards and registers the decoded bundle into the ID/EX register.
module id_stage #(
   parameter int XLEN      = 32,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd_addr,
   input  logic [XLEN-1:0] wb_rd_data,
   input  logic            ex_load_valid,
   input  logic [4:0]      ex_load_rd,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd_addr,
   output logic [3:0]      ex_alu_op,
   output logic [7:0]      ex_ctrl,
   output logic            ex_illegal
);

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                          ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

   localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                          OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                          OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [4:0] rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opc      = if_instr[6:0];
   assign f3       = if_instr[14:12];
   assign rd       = if_instr[11:7];
   assign rs1_addr = if_instr[19:15];
   assign rs2_addr = if_instr[24:20];

   assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
   assign imm_u = {if_instr[31:12], 12'b0};
   assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

   logic [3:0]      alu_d;
   logic [XLEN-1:0] imm_d;
   logic            rw, ld, st, br, jal, jalr, use_imm, use_pc, ill;
   logic            rs1_used, rs2_used;
   logic [7:0]      ctrl_d;

   always_comb begin
      alu_d    = ALU_ADD;
      imm_d    = '0;
      rw       = 1'b0;
      ld       = 1'b0;
      st       = 1'b0;
      br       = 1'b0;
      jal      = 1'b0;
      jalr     = 1'b0;
      use_imm  = 1'b0;
      use_pc   = 1'b0;
      ill      = 1'b0;
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      case (opc)
         OPC_LUI: begin
            alu_d = ALU_PASSB; imm_d = imm_u; rw = 1'b1; use_imm = 1'b1; rs1_used = 1'b0;
         end
         OPC_AUIPC: begin
            imm_d = imm_u; rw = 1'b1; use_imm = 1'b1; use_pc = 1'b1; rs1_used = 1'b0;
         end
         OPC_JAL: begin
            imm_d = imm_j; rw = 1'b1; jal = 1'b1; rs1_used = 1'b0;
         end
         OPC_JALR: begin
            imm_d = imm_i; rw = 1'b1; jalr = 1'b1; use_imm = 1'b1;
         end
         OPC_BRANCH: begin
            imm_d = imm_b; br = 1'b1; rs2_used = 1'b1;
            case (f3[2:1])
               2'b10:   alu_d = ALU_SLT;
               2'b11:   alu_d = ALU_SLTU;
               default: alu_d = ALU_SUB;
            endcase
         end
         OPC_LOAD: begin
            imm_d = imm_i; rw = 1'b1; ld = 1'b1; use_imm = 1'b1;
         end
         OPC_STORE: begin
            imm_d = imm_s; st = 1'b1; use_imm = 1'b1; rs2_used = 1'b1;
         end
         OPC_OPIMM, OPC_OP: begin
            rw = 1'b1;
            if (opc == OPC_OPIMM) begin
               imm_d = imm_i; use_imm = 1'b1;
            end else begin
               rs2_used = 1'b1;
            end
            case (f3)
               3'b000:  alu_d = (opc == OPC_OP && if_instr[30]) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_d = ALU_SLL;
               3'b010:  alu_d = ALU_SLT;
               3'b011:  alu_d = ALU_SLTU;
               3'b100:  alu_d = ALU_XOR;
               3'b101:  alu_d = if_instr[30] ? ALU_SRA : ALU_SRL;
               3'b110:  alu_d = ALU_OR;
               default: alu_d = ALU_AND;
            endcase
         end
         default: ill = 1'b1;
      endcase
      ctrl_d = {rw && (rd != 5'd0), ld, st, br, jal, jalr, use_imm, use_pc};
   end

   // x0 reads as zero; a same-cycle WB write wins over the stale reg_file value
   logic [XLEN-1:0] rs1_val_d, rs2_val_d;
   always_comb begin
      rs1_val_d = rs1_data;
      rs2_val_d = rs2_data;
      if (rs1_addr == 5'd0) rs1_val_d = '0;
      else if (BYPASS_EN && wb_reg_write && wb_rd_addr == rs1_addr) rs1_val_d = wb_rd_data;
      if (rs2_addr == 5'd0) rs2_val_d = '0;
      else if (BYPASS_EN && wb_reg_write && wb_rd_addr == rs2_addr) rs2_val_d = wb_rd_data;
   end

   logic stall, xfer;
   logic ex_valid_q;

   assign stall = if_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                  ((rs1_used && ex_load_rd == rs1_addr) || (rs2_used && ex_load_rd == rs2_addr));
   assign if_ready = !rst && !flush && !stall && (!ex_valid_q || ex_ready);
   assign xfer     = if_valid && if_ready;

   logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
   logic [4:0]      rd_q;
   logic [3:0]      alu_q;
   logic [7:0]      ctrl_q;
   logic            ill_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         pc_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         alu_q      <= '0;
         ctrl_q     <= '0;
         ill_q      <= 1'b0;
      end else if (flush) begin
         ex_valid_q <= 1'b0;
      end else if (xfer) begin
         ex_valid_q <= 1'b1;
         pc_q       <= if_pc;
         rs1_q      <= rs1_val_d;
         rs2_q      <= rs2_val_d;
         imm_q      <= imm_d;
         rd_q       <= rd;
         alu_q      <= alu_d;
         ctrl_q     <= ctrl_d;
         ill_q      <= ill;
      end else if (ex_ready) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_pc      = pc_q;
   assign ex_rs1_val = rs1_q;
   assign ex_rs2_val = rs2_q;
   assign ex_imm     = imm_q;
   assign ex_rd_addr = rd_q;
   assign ex_alu_op  = alu_q;
   assign ex_ctrl    = ctrl_q;
   assign ex_illegal = ill_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, load-use stall, backpressure, flush, illegal, reset.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst, if_valid, if_ready;
   logic [31:0] if_instr, if_pc;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        wb_reg_write;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_data;
   logic        ex_load_valid;
   logic [4:0]  ex_load_rd;
   logic        flush, ex_valid, ex_ready;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rd_addr;
   logic [3:0]  ex_alu_op;
   logic [7:0]  ex_ctrl;
   logic        ex_illegal;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_stage #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_reg_write(wb_reg_write),
      .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data), .ex_load_valid(ex_load_valid),
      .ex_load_rd(ex_load_rd), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
      .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl), .ex_illegal(ex_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; if_valid = 1'b1; if_instr = 32'h00A00293; if_pc = 32'h100;
      rs1_data = 32'h99; rs2_data = 32'h0; wb_reg_write = 1'b0; wb_rd_addr = 5'd0;
      wb_rd_data = 32'h0; ex_load_valid = 1'b0; ex_load_rd = 5'd0; flush = 1'b0; ex_ready = 1'b1;

      // reset with if_valid high
      tick(); tick();
      chk("rst_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_ready", {31'b0, if_ready}, 32'd0);
      chk("rst_imm", ex_imm, 32'd0);
      rst = 1'b0; #1;
      chk("post_rst_ready", {31'b0, if_ready}, 32'd1);

      // ADDI x5,x0,10; ex_load_rd matches the unused rs2 field (10) -> no stall
      ex_load_valid = 1'b1; ex_load_rd = 5'd10; #1;
      chk("addi_nostall", {31'b0, if_ready}, 32'd1);
      tick();
      ex_load_valid = 1'b0;
      chk("addi_valid", {31'b0, ex_valid}, 32'd1);
      chk("addi_alu", {28'b0, ex_alu_op}, 32'd0);
      chk("addi_imm", ex_imm, 32'd10);
      chk("addi_rd", {27'b0, ex_rd_addr}, 32'd5);
      chk("addi_ctrl", {24'b0, ex_ctrl}, 32'h82);
      chk("addi_rs1", ex_rs1_val, 32'd0);
      chk("addi_pc", ex_pc, 32'h100);

      // ADD x3,x1,x2 with WB bypass on rs1
      if_instr = 32'h002081B3; if_pc = 32'h104; rs1_data = 32'd7; rs2_data = 32'd3;
      wb_reg_write = 1'b1; wb_rd_addr = 5'd1; wb_rd_data = 32'h55; #1;
      chk("add_rs1_addr", {27'b0, rs1_addr}, 32'd1);
      chk("add_rs2_addr", {27'b0, rs2_addr}, 32'd2);
      tick();
      chk("byp_rs1", ex_rs1_val, 32'h55);
      chk("byp_rs2", ex_rs2_val, 32'd3);
      chk("add_ctrl", {24'b0, ex_ctrl}, 32'h80);
      wb_rd_addr = 5'd0;
      tick();
      chk("nobyp_rs1", ex_rs1_val, 32'd7);
      wb_reg_write = 1'b0;

      // load-use: SUB x4,x3,x2 while EX loads x3
      if_instr = 32'h40218233; if_pc = 32'h108; ex_load_valid = 1'b1; ex_load_rd = 5'd3; #1;
      chk("lu_ready", {31'b0, if_ready}, 32'd0);
      tick();
      chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
      ex_load_valid = 1'b0; #1;
      chk("lu_release", {31'b0, if_ready}, 32'd1);
      tick();
      chk("sub_valid", {31'b0, ex_valid}, 32'd1);
      chk("sub_alu", {28'b0, ex_alu_op}, 32'd1);
      chk("sub_rd", {27'b0, ex_rd_addr}, 32'd4);

      // BEQ x1,x2,-8 then backpressure for 3 cycles
      if_instr = 32'hFE208CE3; if_pc = 32'h10C;
      tick();
      ex_ready = 1'b0; if_instr = 32'h123453B7; if_pc = 32'h110; #1;
      chk("bp_ready", {31'b0, if_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", {31'b0, ex_valid}, 32'd1);
         chk("bp_imm", ex_imm, 32'hFFFFFFF8);
         chk("bp_ctrl", {24'b0, ex_ctrl}, 32'h10);
         chk("bp_alu", {28'b0, ex_alu_op}, 32'd1);
         chk("bp_pc", ex_pc, 32'h10C);
      end
      ex_ready = 1'b1; #1;
      chk("bp_release", {31'b0, if_ready}, 32'd1);
      tick();
      chk("lui_imm", ex_imm, 32'h12345000);
      chk("lui_alu", {28'b0, ex_alu_op}, 32'd10);
      chk("lui_rd", {27'b0, ex_rd_addr}, 32'd7);
      chk("lui_ctrl", {24'b0, ex_ctrl}, 32'h82);

      // SW x2,-4(x1) and ADDI x0,x0,1 (reg_write suppressed)
      if_instr = 32'hFE20AE23;
      tick();
      chk("sw_imm", ex_imm, 32'hFFFFFFFC);
      chk("sw_ctrl", {24'b0, ex_ctrl}, 32'h22);
      if_instr = 32'h00100013;
      tick();
      chk("x0_ctrl", {24'b0, ex_ctrl}, 32'h02);

      // flush with valid bundle
      flush = 1'b1; #1;
      chk("fl_ready", {31'b0, if_ready}, 32'd0);
      tick();
      chk("fl_valid", {31'b0, ex_valid}, 32'd0);
      flush = 1'b0;

      // illegal opcode flows as a valid bundle
      if_instr = 32'hFFFFFFFF;
      tick();
      chk("ill_flag", {31'b0, ex_illegal}, 32'd1);
      chk("ill_ctrl", {24'b0, ex_ctrl}, 32'h00);
      chk("ill_valid", {31'b0, ex_valid}, 32'd1);
      if_valid = 1'b0;
      tick();
      chk("idle_bubble", {31'b0, ex_valid}, 32'd0);

      // reset during backpressure drops the held bundle
      if_valid = 1'b1; if_instr = 32'h00A00293; if_pc = 32'h200;
      tick();
      ex_ready = 1'b0; rst = 1'b1;
      tick();
      chk("rstbp_valid", {31'b0, ex_valid}, 32'd0);
      chk("rstbp_pc", ex_pc, 32'd0);
      chk("rstbp_imm", ex_imm, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction decode stage, directly upstream of reg_file.
- Takes fetched instructions over a valid/ready handshake and drives rs1_addr/rs2_addr into reg_file. Captures rs1_data/rs2_data with writeback bypass.
- Registers the decoded bundle into the ID/EX pipeline register consumed by the execute stage.
- Detects load-use hazards and stalls.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- BYPASS_EN, 1, enables WB-to-ID bypass of same-cycle register writes.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  this stage accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  instruction PC
- rs1_addr  out  5  to reg_file; combinational from if_instr[19:15]
- rs2_addr  out  5  to reg_file; combinational from if_instr[24:20]
- rs1_data  in  32  from reg_file (combinational read)
- rs2_data  in  32  from reg_file
- wb_reg_write  in  1  writeback write enable (same signal as reg_file reg_write)
- wb_rd_addr  in  5  writeback destination
- wb_rd_data  in  32  writeback data
- ex_load_valid  in  1  EX currently holds a load
- ex_load_rd  in  5  destination of that load
- flush  in  1  squash (branch redirect)
- ex_valid  out  1  ID/EX bundle valid
- ex_ready  in  1  EX accepts the bundle
- ex_pc  out  32  registered PC
- ex_rs1_val  out  32  operand 1
- ex_rs2_val  out  32  operand 2
- ex_imm  out  32  sign-extended immediate
- ex_rd_addr  out  5  destination register
- ex_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- ex_ctrl  out  8  {reg_write, is_load, is_store, is_branch, is_jal, is_jalr, use_imm, use_pc}
- ex_illegal  out  1  undecodable opcode

Behaviour:
- Reset:
  - All ex_* outputs are 0, ex_valid=0, if_ready=0 in the reset cycle.
  - rs1_addr and rs2_addr follow if_instr regardless of rst.
- Operand selection:
  - The value is 0 when the address is 0.
  - Otherwise it is wb_rd_data when BYPASS_EN && wb_reg_write && wb_rd_addr==addr.
  - Otherwise it is the reg_file data.
- Stall: stall = if_valid && ex_load_valid && ex_load_rd!=0 && ex_load_rd matches a used source register.
  - rs2 counts as used only for OP, STORE and BRANCH.
  - rs1 counts as used for all formats except LUI, AUIPC and JAL.
- Ready: if_ready = !rst && !flush && !stall && (!ex_valid || ex_ready).
- Transfer occurs when if_valid && if_ready. The output register then loads the decoded bundle and ex_valid is 1 on the next cycle, giving 1-cycle latency.
- No transfer and ex_ready=1: ex_valid goes to 0, which inserts a bubble. This includes stall cycles.
- ex_valid && !ex_ready: all ex_* outputs hold stable.
- flush: ex_valid goes to 0 next cycle. No transfer occurs that cycle. flush overrides stall and ex_ready.
- Decode by opcode:
  - LUI: PASSB, U-imm.
  - AUIPC: ADD, use_pc, U-imm.
  - JAL: J-imm, is_jal.
  - JALR: I-imm, is_jalr.
  - BRANCH: B-imm, is_branch, reg_write=0, alu_op is SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - LOAD: ADD, I-imm, is_load.
  - STORE: ADD, S-imm, reg_write=0.
  - OP-IMM: funct3 maps to ALU op; SRAI is selected by instr[30].
  - OP: SUB and SRA are selected by instr[30].
- Any other opcode sets ex_illegal=1 with all ctrl bits 0 and ex_valid=1, so the trap flows in order.
- Immediate formats:
  - I-imm: sign from instr[31].
  - S-imm: {instr[31:25], instr[11:7]}.
  - B-imm and J-imm: bit0=0.
  - U-imm: low 12 bits zero.
- reg_write is forced to 0 when rd==0.
- Reset mid-stall or mid-backpressure drops the held bundle; no state survives reset.

Test Plan:
- Reset: rst=1 for 2 cycles with if_valid=1 -> ex_valid=0, if_ready=0. Release -> if_ready=1.
- ADDI x5,x0,10 (0x00A00293), reg_file x0=0 -> 1 cycle later ex_alu_op=0, ex_imm=10, ex_rd_addr=5, use_imm=1, reg_write=1, ex_rs1_val=0.
- Bypass: ADD x3,x1,x2 with rs1_data=7 (stale) and wb_reg_write=1, wb_rd_addr=1, wb_rd_data=0x55 the same cycle -> ex_rs1_val=0x55. Repeat with wb_rd_addr=0 -> ex_rs1_val=7.
- Load-use: ex_load_valid=1, ex_load_rd=3, incoming SUB x4,x3,x2 -> if_ready=0 for that cycle and ex_valid=0 next cycle. Drop ex_load_valid -> transfer, ex_alu_op=1.
- Backpressure: ex_ready=0 for 3 cycles after a BEQ (imm -8) -> bundle held, if_ready=0, ex_imm=0xFFFFFFF8, is_branch=1, reg_write=0. Set ex_ready=1 -> next instruction accepted.
- Flush and illegal: flush=1 with ex_valid=1 -> ex_valid=0 next cycle. Instruction 0xFFFFFFFF -> ex_illegal=1, ex_ctrl=0, ex_valid=1.
